rvfi_retire_fifo: RTL and testbench

Parametrised retirement trace buffer for the RV32I cores. Captures one retire record per cycle from the core's retire strobe, stamps it with a 64-bit retire order, applies RVFI field rules and halt detection, and buffers records in a DEPTH-entry FIFO. The FIFO drains to a trace sink (formal harness, signature writer or log dumper) over a valid/ready handshake. It replaces the free-running per-cycle order counter and fixed halt timer with per-instruction ordering, back-pressure and decoded halt.

---
 rtl/rvfi_retire_fifo.sv | 137 +++++++++++++
 tb/tb_rvfi_retire_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_fifo.sv
// Retirement trace buffer: stamps each retired instruction with a 64-bit order,
// applies RVFI field rules and halt detection, and queues records for a sink.
// Optional feature: define RETIRE_MISALIGN_TRAP_EN to flag misaligned next-PC as a trap.
module rvfi_retire_fifo #(
  parameter int          XLEN       = 32,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] HALT_INSN  = 32'h0000_0073,
  parameter int          MAX_RETIRE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_retire,
  input  logic [31:0]              i_insn,
  input  logic [XLEN-1:0]          i_pc_rdata,
  input  logic [XLEN-1:0]          i_pc_wdata,
  input  logic [4:0]               i_rd_addr,
  input  logic [XLEN-1:0]          i_rd_wdata,
  output logic                     o_ready,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [63:0]              o_order,
  output logic [31:0]              o_insn,
  output logic [XLEN-1:0]          o_pc_rdata,
  output logic [XLEN-1:0]          o_pc_wdata,
  output logic [4:0]               o_rd_addr,
  output logic [XLEN-1:0]          o_rd_wdata,
  output logic                     o_trap,
  output logic                     o_halt,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_halted,
  output logic                     o_overflow
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [63:0] LAST_ORDER = 64'(MAX_RETIRE) - 64'd1;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [63:0]     order;
    logic            halt;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   order;
  logic          halted, overflow;

  logic full, empty, push, pop, drop, trap;
  rec_t wr_rec, head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A halted buffer ignores retires entirely, so they neither push nor count as drops.
  assign push  = i_retire && !full && !halted;
  assign drop  = i_retire &&  full && !halted;
  assign pop   = !empty && i_ready;

`ifdef RETIRE_MISALIGN_TRAP_EN
  logic trap_mem [DEPTH];

  assign trap = (i_pc_wdata[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (push) trap_mem[wr_ptr] <= trap;
  end

  assign o_trap = trap_mem[rd_ptr];
`else
  assign trap   = 1'b0;
  assign o_trap = 1'b0;
`endif

  always_comb begin
    // NOTE: every field gets a value on every path, so no latch can be inferred.
    wr_rec          = '0;
    wr_rec.insn     = i_insn;
    wr_rec.pc_rdata = i_pc_rdata;
    wr_rec.pc_wdata = i_pc_wdata;
    wr_rec.rd_addr  = i_rd_addr;
    wr_rec.rd_wdata = (i_rd_addr == 5'd0) ? '0 : i_rd_wdata;
    wr_rec.order    = order;
    wr_rec.halt     = (i_insn == HALT_INSN)
                   || ((MAX_RETIRE != 0) && (order == LAST_ORDER))
                   || trap;
  end

  // NOTE: the record array has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      order    <= '0;
      halted   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        order  <= order + 64'd1;
        if (wr_rec.halt) halted <= 1'b1;
      end
      if (pop)  rd_ptr   <= rd_ptr + AW'(1);
      if (drop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign o_valid    = !empty;
  assign o_ready    = !full;
  assign o_count    = count;
  assign o_halted   = halted;
  assign o_overflow = overflow;
  assign o_order    = head.order;
  assign o_insn     = head.insn;
  assign o_pc_rdata = head.pc_rdata;
  assign o_pc_wdata = head.pc_wdata;
  assign o_rd_addr  = head.rd_addr;
  assign o_rd_wdata = head.rd_wdata;
  assign o_halt     = head.halt;

endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// Directed bench for rvfi_retire_fifo: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_rvfi_retire_fifo;

  localparam int DEPTH = 8;
  localparam int MAXR  = 0;

  logic        clk, reset;
  logic        i_retire, i_ready;
  logic [31:0] i_insn, i_pc_rdata, i_pc_wdata, i_rd_wdata;
  logic [4:0]  i_rd_addr;
  logic        o_ready, o_valid, o_trap, o_halt, o_halted, o_overflow;
  logic [63:0] o_order;
  logic [31:0] o_insn, o_pc_rdata, o_pc_wdata, o_rd_wdata;
  logic [4:0]  o_rd_addr;
  logic [3:0]  o_count;

  rvfi_retire_fifo #(.XLEN(32), .DEPTH(DEPTH), .HALT_INSN(32'h0000_0073), .MAX_RETIRE(MAXR)) dut (
    .clk(clk), .reset(reset), .i_retire(i_retire), .i_insn(i_insn),
    .i_pc_rdata(i_pc_rdata), .i_pc_wdata(i_pc_wdata), .i_rd_addr(i_rd_addr),
    .i_rd_wdata(i_rd_wdata), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_order(o_order), .o_insn(o_insn), .o_pc_rdata(o_pc_rdata), .o_pc_wdata(o_pc_wdata),
    .o_rd_addr(o_rd_addr), .o_rd_wdata(o_rd_wdata), .o_trap(o_trap), .o_halt(o_halt),
    .o_count(o_count), .o_halted(o_halted), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of expected records.
  typedef struct {
    logic [31:0]     insn, pc_r, pc_w, wd;
    logic [4:0]      rd;
    longint unsigned order;
    bit              halt, trap;
  } rec_t;

  rec_t            q[$];
  longint unsigned m_order;
  bit              m_halted, m_overflow;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_order    = 0;
      m_halted   = 0;
      m_overflow = 0;
    end else begin
      bit   was_full, do_push;
      rec_t r;
      was_full = (q.size() == DEPTH);
      do_push  = i_retire && !was_full && !m_halted;
      if (i_retire && was_full && !m_halted) m_overflow = 1;
      if (q.size() > 0 && i_ready) void'(q.pop_front());
      if (do_push) begin
        r.insn  = i_insn;
        r.pc_r  = i_pc_rdata;
        r.pc_w  = i_pc_wdata;
        r.rd    = i_rd_addr;
        r.wd    = (i_rd_addr == 0) ? 32'd0 : i_rd_wdata;
        r.order = m_order;
`ifdef RETIRE_MISALIGN_TRAP_EN
        r.trap  = (i_pc_wdata % 4) != 0;
`else
        r.trap  = 0;
`endif
        r.halt  = (i_insn == 32'h0000_0073) || (MAXR != 0 && m_order == MAXR - 1) || r.trap;
        q.push_back(r);
        m_order++;
        if (r.halt) m_halted = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("valid",    o_valid,    q.size() != 0);
    check("ready",    o_ready,    q.size() != DEPTH);
    check("count",    o_count,    q.size());
    check("halted",   o_halted,   m_halted);
    check("overflow", o_overflow, m_overflow);
    if (q.size() != 0) begin
      check("order",    o_order,    q[0].order);
      check("insn",     o_insn,     q[0].insn);
      check("pc_rdata", o_pc_rdata, q[0].pc_r);
      check("pc_wdata", o_pc_wdata, q[0].pc_w);
      check("rd_addr",  o_rd_addr,  q[0].rd);
      check("rd_wdata", o_rd_wdata, q[0].wd);
      check("halt",     o_halt,     q[0].halt);
      check("trap",     o_trap,     q[0].trap);
    end
  end

  task automatic drive(input bit ret, input logic [31:0] insn, input logic [31:0] pcr,
                       input logic [31:0] pcw, input logic [4:0] rd, input logic [31:0] wd,
                       input bit rdy);
    i_retire   = ret;
    i_insn     = insn;
    i_pc_rdata = pcr;
    i_pc_wdata = pcw;
    i_rd_addr  = rd;
    i_rd_wdata = wd;
    i_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic [31:0] pc, input bit rdy);
    drive(1'b1, 32'h0000_0013, pc, pc + 32'd4, 5'd1, pc ^ 32'hA5A5_0000, rdy);
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid_now", o_valid, 1'b0);
    check("rst_count_now", o_count, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_retire = 0; i_insn = 0; i_pc_rdata = 0; i_pc_wdata = 0;
    i_rd_addr = 0; i_rd_wdata = 0; i_ready = 0;
    @(posedge clk);
    #1;
    check("reset_valid", o_valid, 1'b0);
    check("reset_ready", o_ready, 1'b1);
    check("reset_count", o_count, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // In-order draining, then steady push+pop with non-empty FIFO.
    for (int i = 0; i < 3; i++) begin
      nop(32'(4 * i), 1'b1);
      check("seq_order", o_order, 64'(i));
    end
    idle(1'b1);
    check("seq_drained", o_count, 4'd0);
    for (int i = 0; i < 3; i++) nop(32'h200 + 32'(4 * i), 1'b0);
    for (int i = 0; i < 4; i++) nop(32'h300 + 32'(4 * i), 1'b1);
    check("pushpop_count", o_count, 4'd3);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Back-pressure: fill, overflow, drain.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      nop(32'h1000 + 32'(4 * i), 1'b0);
      if (i == 7) begin
        check("full_ready", o_ready, 1'b0);
        check("full_ovf_clear", o_overflow, 1'b0);
      end
    end
    check("full_count", o_count, 4'd8);
    check("full_ovf", o_overflow, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check("drain_order", o_order, 64'(k));
      idle(1'b1);
    end
    check("drain_empty", o_valid, 1'b0);

    // x0 write-back is forced to zero.
    do_reset();
    drive(1'b1, 32'h0000_0013, 32'h0, 32'h4, 5'd0, 32'hDEAD_BEEF, 1'b0);
    check("x0_wdata", o_rd_wdata, 32'd0);
    idle(1'b1);

    // ecall at order 5 halts the buffer; later retires are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) nop(32'(4 * i), 1'b0);
    drive(1'b1, 32'h0000_0073, 32'h14, 32'h18, 5'd0, 32'h0, 1'b0);
    check("halt_sticky", o_halted, 1'b1);
    check("halt_count", o_count, 4'd6);
    nop(32'h18, 1'b0);
    nop(32'h1c, 1'b0);
    check("halt_ignored", o_count, 4'd6);
    check("halt_no_ovf", o_overflow, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        check("halt_rec_order", o_order, 64'd5);
        check("halt_rec_flag", o_halt, 1'b1);
      end
      idle(1'b1);
    end
    nop(32'h40, 1'b1);
    check("halt_after_drain", o_valid, 1'b0);

    // Misaligned next-PC.
    do_reset();
    drive(1'b1, 32'h0000_0013, 32'h100, 32'h102, 5'd1, 32'h5, 1'b0);
`ifdef RETIRE_MISALIGN_TRAP_EN
    check("trap_flag", o_trap, 1'b1);
    check("trap_halt", o_halt, 1'b1);
`else
    check("trap_flag", o_trap, 1'b0);
    check("trap_halt", o_halt, 1'b0);
`endif
    idle(1'b1);

    // Reset mid-operation discards records and restarts ordering.
    do_reset();
    for (int i = 0; i < 4; i++) nop(32'h500 + 32'(4 * i), 1'b0);
    check("pre_rst_count", o_count, 4'd4);
    do_reset();
    nop(32'h600, 1'b0);
    check("post_rst_order", o_order, 64'd0);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
